// File: rtl/clint_pkg.sv
// Purpose : shared register offsets, reset constants and byte-merge helper for the CLINT.
// Ports   : none (package).
// Config  : CLINT_MSIP_EN (see riscv_clint) uses MSIP_OFF.
package clint_pkg;

  // Word offsets relative to the CLINT base address.
  localparam logic [31:0] MSIP_OFF        = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_LO_OFF = 32'h0000_4000;
  localparam logic [31:0] MTIMECMP_HI_OFF = 32'h0000_4004;
  localparam logic [31:0] MTIME_LO_OFF    = 32'h0000_BFF8;
  localparam logic [31:0] MTIME_HI_OFF    = 32'h0000_BFFC;

  // All-ones compare value keeps the timer interrupt quiet out of reset.
  localparam logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace the bytes of old_v selected by strb with the matching bytes of new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Purpose : free-running 64-bit mtime with a PRESCALE-cycle tick and byte-masked per-half load.
// Ports   : clk, rst (async active-high); i_wr_lo/i_wr_hi load strobes, i_wstrb byte mask,
//           i_wdata load data; o_mtime current count.
module clint_mtime_counter
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_mtime
);

  localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic [63:0]   r_mtime;
  logic          w_tick;

  // With PRESCALE == 1 the prescaler sits at 0 and every cycle is a tick.
  assign w_tick = (r_pre == PRE_MAX);

  // The prescaler keeps running through mtime writes so the tick cadence
  // never depends on software activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // A load to either half suppresses the increment on that edge entirely,
  // so the untouched half can never see a stray carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= '0;
    end else if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) r_mtime[31:0]  <= byte_merge(r_mtime[31:0],  i_wdata, i_wstrb);
      if (i_wr_hi) r_mtime[63:32] <= byte_merge(r_mtime[63:32], i_wdata, i_wstrb);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/riscv_clint.sv
// Purpose : RISC-V CLINT subset - mtime/mtimecmp register file with level timer interrupt.
// Ports   : clk, rst (async active-high); addr/wdata/wstrb/read_en bus inputs; rdata and
//           addr_valid combinational; timer_irq = (mtime >= mtimecmp); soft_irq with CLINT_MSIP_EN.
// Config  : define CLINT_MSIP_EN to add the msip register at +0x0000 and the soft_irq output.
module riscv_clint
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        read_en,
  output logic [31:0] rdata,
  output logic        addr_valid,
  output logic        timer_irq
`ifdef CLINT_MSIP_EN
  ,
  output logic        soft_irq
`endif
);

  localparam logic [31:0] A_MSIP   = BASE_ADDR + MSIP_OFF;
  localparam logic [31:0] A_CMP_LO = BASE_ADDR + MTIMECMP_LO_OFF;
  localparam logic [31:0] A_CMP_HI = BASE_ADDR + MTIMECMP_HI_OFF;
  localparam logic [31:0] A_TIM_LO = BASE_ADDR + MTIME_LO_OFF;
  localparam logic [31:0] A_TIM_HI = BASE_ADDR + MTIME_HI_OFF;

  logic        w_sel_msip;
  logic        w_sel_cmp_lo;
  logic        w_sel_cmp_hi;
  logic        w_sel_tim_lo;
  logic        w_sel_tim_hi;
  logic        w_we;
  logic [63:0] w_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] w_rdata;
  logic        w_msip;
  logic        w_unused_addr;

  // Byte-lane bits of the address carry no information for word registers.
  assign w_unused_addr = ^addr[1:0];

  assign w_sel_cmp_lo = (addr[31:2] == A_CMP_LO[31:2]);
  assign w_sel_cmp_hi = (addr[31:2] == A_CMP_HI[31:2]);
  assign w_sel_tim_lo = (addr[31:2] == A_TIM_LO[31:2]);
  assign w_sel_tim_hi = (addr[31:2] == A_TIM_HI[31:2]);

`ifdef CLINT_MSIP_EN
  logic r_msip;

  assign w_sel_msip = (addr[31:2] == A_MSIP[31:2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msip <= 1'b0;
    end else if (w_we && w_sel_msip && wstrb[0]) begin
      r_msip <= wdata[0];
    end
  end

  assign w_msip   = r_msip;
  assign soft_irq = r_msip;
`else
  logic w_unused_msip;

  assign w_sel_msip    = 1'b0;
  assign w_msip        = 1'b0;
  assign w_unused_msip = ^A_MSIP;
`endif

  assign addr_valid = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi | w_sel_tim_lo | w_sel_tim_hi;

  // Any strobe bit on a decoded word is a write; misses are silently dropped.
  assign w_we = addr_valid & (|wstrb);

  clint_mtime_counter #(
    .PRESCALE (PRESCALE)
  ) u_mtime (
    .clk     (clk),
    .rst     (rst),
    .i_wr_lo (w_we & w_sel_tim_lo),
    .i_wr_hi (w_we & w_sel_tim_hi),
    .i_wstrb (wstrb),
    .i_wdata (wdata),
    .o_mtime (w_mtime)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtimecmp <= MTIMECMP_RESET;
    end else if (w_we) begin
      if (w_sel_cmp_lo) r_mtimecmp[31:0]  <= byte_merge(r_mtimecmp[31:0],  wdata, wstrb);
      if (w_sel_cmp_hi) r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], wdata, wstrb);
    end
  end

  // Read mux sees only current register state, so a same-cycle write
  // is observed as the pre-write value.
  always_comb begin
    w_rdata = 32'h0;
    if (read_en) begin
      if (w_sel_msip)   w_rdata = {31'h0, w_msip};
      if (w_sel_cmp_lo) w_rdata = r_mtimecmp[31:0];
      if (w_sel_cmp_hi) w_rdata = r_mtimecmp[63:32];
      if (w_sel_tim_lo) w_rdata = w_mtime[31:0];
      if (w_sel_tim_hi) w_rdata = w_mtime[63:32];
    end
  end

  assign rdata     = w_rdata;
  assign timer_irq = (w_mtime >= r_mtimecmp);

endmodule

// File: tb/tb_riscv_clint.sv
// Purpose : scoreboard bench for riscv_clint - random and directed bus traffic against a
//           time-based reference model; a negedge monitor checks rdata/addr_valid/timer_irq.
// Config  : honours CLINT_MSIP_EN the same way as the design.
module tb_riscv_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] A_CL = BASE + 32'h4000;
  localparam logic [31:0] A_CH = BASE + 32'h4004;
  localparam logic [31:0] A_TL = BASE + 32'hBFF8;
  localparam logic [31:0] A_TH = BASE + 32'hBFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        read_en;
  logic [31:0] rdata;
  logic        addr_valid;
  logic        timer_irq;
`ifdef CLINT_MSIP_EN
  logic        soft_irq;
`endif

  riscv_clint #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .read_en    (read_en),
    .rdata      (rdata),
    .addr_valid (addr_valid),
    .timer_irq  (timer_irq)
`ifdef CLINT_MSIP_EN
    ,
    .soft_irq   (soft_irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        av;
    logic        irq;
    logic        sirq;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mtime is "value at a reference edge plus edges elapsed since".
  logic [63:0] cyc;
  logic [63:0] m_base;
  logic [63:0] m_edge;
  logic [63:0] m_cmp;
  logic        m_msip;

  function automatic logic [63:0] m_time();
    return m_base + (cyc - m_edge);
  endfunction

  function automatic bit m_valid(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
`ifdef CLINT_MSIP_EN
    if (w == BASE) return 1'b1;
`endif
    return (w == A_CL) || (w == A_CH) || (w == A_TL) || (w == A_TH);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    logic [63:0] t;
    w = {a[31:2], 2'b00};
    t = m_time();
    if (w == A_CL) return m_cmp[31:0];
    if (w == A_CH) return m_cmp[63:32];
    if (w == A_TL) return t[31:0];
    if (w == A_TH) return t[63:32];
`ifdef CLINT_MSIP_EN
    if (w == BASE) return {31'h0, m_msip};
`endif
    return 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                       input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_base = 64'h0;
    m_edge = cyc;
    m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: the DUT presents a combinational response every cycle; compare it
  // mid-cycle against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".rdata"},      rdata,             e.rd);
      chk({e.nm, ".addr_valid"}, {31'h0, addr_valid}, {31'h0, e.av});
      chk({e.nm, ".timer_irq"},  {31'h0, timer_irq},  {31'h0, e.irq});
`ifdef CLINT_MSIP_EN
      chk({e.nm, ".soft_irq"},   {31'h0, soft_irq},   {31'h0, e.sirq});
`endif
    end
  end

  // One bus cycle. Entered just after a rising edge; leaves just after the next one.
  task automatic step(input string nm, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit rd);
    exp_t        e;
    logic [63:0] t_prev;
    logic [31:0] w;
    addr    = a;
    wdata   = wd;
    wstrb   = st;
    read_en = rd;
    e.nm   = nm;
    e.av   = m_valid(a);
    e.rd   = (rd && e.av) ? m_read(a) : 32'h0;
    e.irq  = (m_time() >= m_cmp);
    e.sirq = m_msip;
    q.push_back(e);
    t_prev = m_time();
    w      = {a[31:2], 2'b00};
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else if (st != 4'h0 && e.av) begin
      if (w == A_CL) m_cmp[31:0]  = merge(m_cmp[31:0],  wd, st);
      if (w == A_CH) m_cmp[63:32] = merge(m_cmp[63:32], wd, st);
      if (w == A_TL) begin
        m_base = {t_prev[63:32], merge(t_prev[31:0], wd, st)};
        m_edge = cyc;
      end
      if (w == A_TH) begin
        m_base = {merge(t_prev[63:32], wd, st), t_prev[31:0]};
        m_edge = cyc;
      end
`ifdef CLINT_MSIP_EN
      if (w == BASE && st[0]) m_msip = wd[0];
`endif
    end
    #1;
  endtask

  task automatic rd_(input string nm, input logic [31:0] a);
    step(nm, a, 32'h0, 4'h0, 1'b1);
  endtask

  task automatic wr_(input string nm, input logic [31:0] a, input logic [31:0] d);
    step(nm, a, d, 4'hF, 1'b0);
  endtask

  logic [31:0] pool [8];

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wstrb = '0; read_en = 1'b0;
    cyc = 64'h0;
    model_reset();
    @(posedge clk);
    #1;

    // Held in reset: everything at reset values, writes have no effect.
    rd_("rst_mtime", A_TL);
    rd_("rst_cmp_lo", A_CL);
    wr_("rst_wr_cmp", A_CL, 32'h0);
    rd_("rst_cmp_after_wr", A_CL);

    rst = 1'b0;
    rd_("t0", A_TL);
    repeat (9) step("idle", 32'h0, 32'h0, 4'h0, 1'b0);
    rd_("t10", A_TL);
    rd_("t10_hi", A_TH);
    rd_("cmp_lo_reset", A_CL);
    rd_("cmp_hi_reset", A_CH);

    wr_("wr_cmp_lo", A_CL, 32'h10);
    wr_("wr_cmp_hi", A_CH, 32'h0);
    rd_("cmp_lo_rb", A_CL);
    wr_("wr_cmp_lo_ff", A_CL, 32'hFFFF_FFFF);
    wr_("wr_cmp_hi_ff", A_CH, 32'hFFFF_FFFF);
    rd_("irq_cleared", A_CH);

    wr_("wr_mt_lo", A_TL, 32'h1234_5678);
    wr_("wr_mt_hi", A_TH, 32'h0);
    rd_("mt_lo_rb", A_TL);
    rd_("mt_hi_rb", A_TH);

    rd_("av_bff8", A_TL);
    rd_("av_4000", A_CL);
    rd_("av_00001000", 32'h0000_1000);
    rd_("av_02001000", 32'h0200_1000);
    rd_("av_base", BASE);
    rd_("av_unaligned", A_CL + 32'h3);

    // Same-cycle read and write of one word returns the old contents.
    step("rdw_cmp", A_CL, 32'hAAAA_5555, 4'hF, 1'b1);
    rd_("rdw_after", A_CL);
    step("strb_cmp", A_CL, 32'h1122_3344, 4'b0101, 1'b1);
    rd_("strb_rb", A_CL);
    step("rdw_mtime", A_TL, 32'h0000_0100, 4'b0010, 1'b1);
    rd_("mt_strb_rb", A_TL);

    // Threshold: cmp = 2^32, count mtime across the carry into the high word.
    wr_("eq_cmp_hi", A_CH, 32'h1);
    wr_("eq_cmp_lo", A_CL, 32'h0);
    wr_("eq_mt_hi", A_TH, 32'h0);
    wr_("eq_mt_lo", A_TL, 32'hFFFF_FFFC);
    repeat (5) rd_("eq_carry", A_TL);
    wr_("eq_mt_lo0", A_TL, 32'h0);
    rd_("eq_lo0", A_TH);
    wr_("eq_mt_hi1", A_TH, 32'h1);
    rd_("eq_hi1", A_TL);

    // 64-bit wrap is silent.
    wr_("wrap_hi", A_TH, 32'hFFFF_FFFF);
    wr_("wrap_lo", A_TL, 32'hFFFF_FFFE);
    repeat (3) rd_("wrap", A_TH);

    pool[0] = A_CL; pool[1] = A_CH; pool[2] = A_TL; pool[3] = A_TH;
    pool[4] = BASE; pool[5] = 32'h0200_1000; pool[6] = 32'h0000_1000; pool[7] = 32'h0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = pool[$urandom_range(0, 7)];
      if (a == 32'h0) a = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      step("rand", a, $urandom, s, $urandom_range(0, 1) == 1);
    end

    // Reset asserted between edges takes effect immediately.
    wr_("pre_rst_cmp", A_CL, 32'h5);
    rst = 1'b1;
    model_reset();
    rd_("async_rst_cmp", A_CL);
    rd_("async_rst_mt", A_TL);
    rst = 1'b0;
    repeat (3) rd_("post_rst_mt", A_TL);

    step("idle_end", 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
